uart_rx_ctrl: RTL and testbench

//  Register-mapped controller for the UART receiver: holds receiver config (frame format, baud limit, enable),

---
 rtl/uart_rx_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Register-mapped UART receiver controller: staged config, RX FIFO, sticky flags, IRQ.
// Optional idle-timeout detection enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
   parameter int          FIFO_AW      = 3,
   parameter logic [13:0] RESET_BAUD   = 14'd129,
   parameter int          TIMEOUT_BITS = 40
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  Addr,
   input  logic        WrEn,
   input  logic        RdEn,
   input  logic [31:0] WrData,
   output logic [31:0] RdData,
   output logic        Irq,
   output logic        RxEnable,
   output logic [2:0]  RxDataLenLimit,
   output logic        RxStopLenLimit,
   output logic        RxParityEn,
   output logic        RxParityPol,
   output logic [13:0] RxBaudLimit,
   input  logic        RxReady,
   input  logic [7:0]  RxData,
   input  logic        RxParityErr,
   input  logic        RxFrameErr,
   input  logic        RxBusy
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = FIFO_AW + 1;

   typedef enum logic [1:0] {CFG_IDLE, CFG_PEND, CFG_APPLY} cfg_e;

   cfg_e state_q, state_d;
   logic en_q, en_d, ie_rx_q, ie_rx_d, ie_err_q, ie_err_d;
   logic [2:0] sh_dlen_q, sh_dlen_d, dlen_q, dlen_d;
   logic sh_stop_q, sh_stop_d, stop_q, stop_d;
   logic sh_pen_q, sh_pen_d, pen_q, pen_d;
   logic sh_ppol_q, sh_ppol_d, ppol_q, ppol_d;
   logic [13:0] sh_baud_q, sh_baud_d, baud_q, baud_d;
   logic [7:0] mem_q [DEPTH], mem_d [DEPTH];
   logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic ovr_q, ovr_d, par_q, par_d, frm_q, frm_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic irq_q, irq_d;

   logic wr_ctrl, wr_baud, wr_stat, cfg_wr, rd_fifo;
   logic avail, full, push, pop, push_ok, timeout;
   logic [31:0] status;

   assign wr_ctrl = WrEn && (Addr == 2'd0);
   assign wr_baud = WrEn && (Addr == 2'd1);
   assign wr_stat = WrEn && (Addr == 2'd2);
   assign cfg_wr  = wr_ctrl || wr_baud;
   assign rd_fifo = RdEn && (Addr == 2'd3);
   assign avail   = (count_q != '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop     = rd_fifo && avail;
   assign push    = RxReady && !RxParityErr && !RxFrameErr;
   // A pop in the same cycle frees the slot the push needs
   assign push_ok = push && (!full || pop);

`ifdef UART_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_BITS + 1);
   logic [13:0] bt_q, bt_d;
   logic [TW-1:0] idl_q, idl_d;
   logic fired_q, fired_d, tmo_q, tmo_d;

   always_comb begin
      bt_d    = bt_q;
      idl_d   = idl_q;
      fired_d = fired_q;
      tmo_d   = tmo_q && !(wr_stat && WrData[6]);
      if (!avail || RxBusy || push_ok || pop) begin
         bt_d    = '0;
         idl_d   = '0;
         fired_d = 1'b0;
      end else if (bt_q >= baud_q) begin
         bt_d = '0;
         if (idl_q != TW'(TIMEOUT_BITS))
            idl_d = idl_q + TW'(1);
      end else begin
         bt_d = bt_q + 14'd1;
      end
      if ((idl_d == TW'(TIMEOUT_BITS)) && !fired_q) begin
         tmo_d   = 1'b1;
         fired_d = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         bt_q    <= '0;
         idl_q   <= '0;
         fired_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         bt_q    <= bt_d;
         idl_q   <= idl_d;
         fired_q <= fired_d;
         tmo_q   <= tmo_d;
      end
   end

   assign timeout = tmo_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      status = '0;
      status[0] = avail;
      status[1] = full;
      status[2] = ovr_q;
      status[3] = par_q;
      status[4] = frm_q;
      status[5] = RxBusy;
      status[6] = timeout;
      status[7] = (state_q != CFG_IDLE);
      status[FIFO_AW+8:8] = count_q;
   end

   always_comb begin
      en_d      = en_q;
      ie_rx_d   = ie_rx_q;
      ie_err_d  = ie_err_q;
      sh_dlen_d = sh_dlen_q;
      sh_stop_d = sh_stop_q;
      sh_pen_d  = sh_pen_q;
      sh_ppol_d = sh_ppol_q;
      sh_baud_d = sh_baud_q;
      if (wr_ctrl) begin
         en_d      = WrData[0];
         sh_dlen_d = WrData[3:1];
         sh_stop_d = WrData[4];
         sh_pen_d  = WrData[5];
         sh_ppol_d = WrData[6];
         ie_rx_d   = WrData[8];
         ie_err_d  = WrData[9];
      end
      if (wr_baud)
         sh_baud_d = WrData[13:0];
   end

   // Live staged fields only move in APPLY with the receiver idle
   always_comb begin
      state_d = state_q;
      dlen_d  = dlen_q;
      stop_d  = stop_q;
      pen_d   = pen_q;
      ppol_d  = ppol_q;
      baud_d  = baud_q;
      unique case (state_q)
         CFG_IDLE: if (cfg_wr) state_d = RxBusy ? CFG_PEND : CFG_APPLY;
         CFG_PEND: if (!RxBusy) state_d = CFG_APPLY;
         CFG_APPLY: begin
            if (RxBusy) begin
               state_d = CFG_PEND;
            end else begin
               dlen_d  = sh_dlen_q;
               stop_d  = sh_stop_q;
               pen_d   = sh_pen_q;
               ppol_d  = sh_ppol_q;
               baud_d  = sh_baud_q;
               state_d = cfg_wr ? CFG_PEND : CFG_IDLE;
            end
         end
         default: state_d = CFG_IDLE;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (push_ok)
         mem_d[wptr_q] = RxData;
      wptr_d  = wptr_q + FIFO_AW'(push_ok);
      rptr_d  = rptr_q + FIFO_AW'(pop);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      ovr_d = (ovr_q && !(wr_stat && WrData[2])) || (push && full && !pop);
      par_d = (par_q && !(wr_stat && WrData[3])) || RxParityErr;
      frm_d = (frm_q && !(wr_stat && WrData[4])) || RxFrameErr;
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (RdEn) begin
         unique case (Addr)
            2'd0: rd_data_d = {22'd0, ie_err_q, ie_rx_q, 1'b0, sh_ppol_q,
                               sh_pen_q, sh_stop_q, sh_dlen_q, en_q};
            2'd1: rd_data_d = {18'd0, sh_baud_q};
            2'd2: rd_data_d = status;
            2'd3: rd_data_d = avail ? {24'd0, mem_q[rptr_q]} : 32'h8000_0000;
         endcase
      end
      irq_d = (ie_rx_q && avail) ||
              (ie_err_q && (ovr_q || par_q || frm_q || timeout));
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= CFG_IDLE;
         en_q      <= 1'b0;
         ie_rx_q   <= 1'b0;
         ie_err_q  <= 1'b0;
         sh_dlen_q <= 3'd7;
         sh_stop_q <= 1'b0;
         sh_pen_q  <= 1'b0;
         sh_ppol_q <= 1'b0;
         sh_baud_q <= RESET_BAUD;
         dlen_q    <= 3'd7;
         stop_q    <= 1'b0;
         pen_q     <= 1'b0;
         ppol_q    <= 1'b0;
         baud_q    <= RESET_BAUD;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         ovr_q     <= 1'b0;
         par_q     <= 1'b0;
         frm_q     <= 1'b0;
         rd_data_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         ie_rx_q   <= ie_rx_d;
         ie_err_q  <= ie_err_d;
         sh_dlen_q <= sh_dlen_d;
         sh_stop_q <= sh_stop_d;
         sh_pen_q  <= sh_pen_d;
         sh_ppol_q <= sh_ppol_d;
         sh_baud_q <= sh_baud_d;
         dlen_q    <= dlen_d;
         stop_q    <= stop_d;
         pen_q     <= pen_d;
         ppol_q    <= ppol_d;
         baud_q    <= baud_d;
         mem_q     <= mem_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         ovr_q     <= ovr_d;
         par_q     <= par_d;
         frm_q     <= frm_d;
         rd_data_q <= rd_data_d;
         irq_q     <= irq_d;
      end
   end

   assign RdData         = rd_data_q;
   assign Irq            = irq_q;
   assign RxEnable       = en_q;
   assign RxDataLenLimit = dlen_q;
   assign RxStopLenLimit = stop_q;
   assign RxParityEn     = pen_q;
   assign RxParityPol    = ppol_q;
   assign RxBaudLimit    = baud_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_ctrl;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [1:0]  Addr = '0;
   logic        WrEn = 1'b0;
   logic        RdEn = 1'b0;
   logic [31:0] WrData = '0;
   logic [31:0] RdData;
   logic        Irq;
   logic        RxEnable;
   logic [2:0]  RxDataLenLimit;
   logic        RxStopLenLimit;
   logic        RxParityEn;
   logic        RxParityPol;
   logic [13:0] RxBaudLimit;
   logic        RxReady = 1'b0;
   logic [7:0]  RxData = '0;
   logic        RxParityErr = 1'b0;
   logic        RxFrameErr = 1'b0;
   logic        RxBusy = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] r;
   logic [7:0]  exp_b;

   uart_rx_ctrl dut (
      .Clock(Clock), .Reset(Reset), .Addr(Addr), .WrEn(WrEn), .RdEn(RdEn),
      .WrData(WrData), .RdData(RdData), .Irq(Irq), .RxEnable(RxEnable),
      .RxDataLenLimit(RxDataLenLimit), .RxStopLenLimit(RxStopLenLimit),
      .RxParityEn(RxParityEn), .RxParityPol(RxParityPol),
      .RxBaudLimit(RxBaudLimit), .RxReady(RxReady), .RxData(RxData),
      .RxParityErr(RxParityErr), .RxFrameErr(RxFrameErr), .RxBusy(RxBusy)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(negedge Clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = a; WrData = d; WrEn = 1'b1;
      tick();
      WrEn = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      Addr = a; RdEn = 1'b1;
      tick();
      RdEn = 1'b0;
      d = RdData;
   endtask

   task automatic push(input logic [7:0] b);
      RxData = b; RxReady = 1'b1;
      tick();
      RxReady = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      Reset = 1'b1;
      tick();
      chk("rst_irq", {31'd0, Irq}, 32'd0);
      chk("rst_en", {31'd0, RxEnable}, 32'd0);
      chk("rst_dlen", {29'd0, RxDataLenLimit}, 32'd7);
      chk("rst_baud", {18'd0, RxBaudLimit}, 32'd129);
      rd(2'd0, r); chk("rst_ctrl", r, 32'h0000_000E);
      rd(2'd1, r); chk("rst_baudreg", r, 32'd129);
      rd(2'd2, r); chk("rst_status", r, 32'd0);
      rd(2'd3, r); chk("rst_data", r, 32'h8000_0000);

      wr(2'd0, 32'h0000_010F);
      tick();
      chk("rx_enable", {31'd0, RxEnable}, 32'd1);
      push(8'hA5);
      push(8'h3C);
      rd(2'd2, r); chk("two_status", r, 32'h0000_0201);
      chk("two_irq", {31'd0, Irq}, 32'd1);
      rd(2'd3, r); chk("pop_a5", r, 32'h0000_00A5);
      rd(2'd3, r); chk("pop_3c", r, 32'h0000_003C);
      tick();
      chk("irq_clear", {31'd0, Irq}, 32'd0);
      chk("rd_hold", RdData, 32'h0000_003C);
      rd(2'd3, r); chk("empty_data", r, 32'h8000_0000);

      for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
      rd(2'd2, r); chk("full_status", r, 32'h0000_0807);
      chk("full_irq", {31'd0, Irq}, 32'd1);
      wr(2'd2, 32'h0000_0004);
      rd(2'd2, r); chk("ovr_w1c", r, 32'h0000_0803);

      RxData = 8'h99; RxReady = 1'b1; Addr = 2'd3; RdEn = 1'b1;
      tick();
      RxReady = 1'b0; RdEn = 1'b0;
      chk("fullpp_head", RdData, 32'h0000_0010);
      rd(2'd2, r); chk("fullpp_status", r, 32'h0000_0803);
      for (int k = 0; k < 8; k++) begin
         exp_b = (k < 7) ? 8'h11 + 8'(k) : 8'h99;
         rd(2'd3, r); chk("drain", r, {24'd0, exp_b});
      end

      RxBusy = 1'b1;
      wr(2'd1, 32'd1562);
      tick();
      chk("busy_baud", {18'd0, RxBaudLimit}, 32'd129);
      rd(2'd2, r); chk("pend_status", r, 32'h0000_00A0);
      rd(2'd1, r); chk("shadow_baud", r, 32'd1562);
      RxBusy = 1'b0;
      tick();
      chk("apply_wait", {18'd0, RxBaudLimit}, 32'd129);
      tick();
      chk("apply_baud", {18'd0, RxBaudLimit}, 32'd1562);
      rd(2'd2, r); chk("idle_status", r, 32'd0);

      wr(2'd0, 32'h0000_020F);
      RxParityErr = 1'b1;
      tick();
      RxParityErr = 1'b0;
      tick();
      chk("par_irq", {31'd0, Irq}, 32'd1);
      rd(2'd2, r); chk("par_status", r, 32'h0000_0008);
      RxFrameErr = 1'b1;
      wr(2'd2, 32'h0000_0018);
      RxFrameErr = 1'b0;
      rd(2'd2, r); chk("set_wins", r, 32'h0000_0010);
      wr(2'd2, 32'h0000_007C);
      tick();
      chk("err_irq_clr", {31'd0, Irq}, 32'd0);

      wr(2'd1, 32'd3);
      repeat (3) tick();
      chk("baud3", {18'd0, RxBaudLimit}, 32'd3);
      push(8'h42);
      repeat (170) tick();
      rd(2'd2, r);
`ifdef UART_RX_TIMEOUT_EN
      chk("timeout_bit", r & 32'h40, 32'h40);
      chk("timeout_irq", {31'd0, Irq}, 32'd1);
`else
      chk("no_timeout", r, 32'h0000_0101);
      chk("no_tmo_irq", {31'd0, Irq}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
